blitrd_port: RTL and testbench
==============================

BLITRD_PORT -- requirements
Module: blitrd_port

Interface
REQ-001 SHALL have these ports: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have these ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have these ports: bliten  in  1  blitter register space selected.
REQ-004 SHALL have these ports: gpu_memw  in  1  1=write, 0=read cycle.
REQ-005 SHALL have these ports: gpu_rreq  in  1  one-cycle read request strobe.
REQ-006 SHALL have these ports: gpu_addr  in  8  byte offset; bits [1:0] ignored.
REQ-007 SHALL have these ports: posupd  in  1  address generator updating A1/A2 position this cycle.
REQ-008 SHALL have these ports: a1_x, a1_y, a2_x, a2_y  in  16 each  live pixel positions.
REQ-009 SHALL have these ports: a1_fx, a1_fy  in  16 each  live fractional positions.
REQ-010 SHALL have these ports: idle  in  1  blitter idle.
REQ-011 SHALL have these ports: stopped  in  1  collision-stop condition, level.
REQ-012 SHALL have these ports: gpu_dout  out  32  read data.
REQ-013 SHALL have these ports: gpu_dout_en  out  1  bus drive enable.
REQ-014 SHALL have these ports: gpu_rack  out  1  one-cycle read acknowledge.
REQ-015 SHALL have these ports: busy  out  1  transaction in progress.

Function
REQ-016 A read SHALL be accepted only when gpu_rreq=1, bliten=1, gpu_memw=0 and state=IDLE; gpu_rreq with any other qualifier, or while busy, SHALL be ignored, not queued.
REQ-017 Decode of gpu_addr[7:2] SHALL be: 0x04 A1POS={a1_y,a1_x}; 0x18 A1POSF={a1_fy,a1_fx}; 0x2C A2POS={a2_y,a2_x}; 0x38 STATUS={30'b0,stop_sticky,idle}; every other offset SHALL return 32'h0.
REQ-018 States SHALL be IDLE, WAIT, CAPT, DRIVE; accept moves IDLE->WAIT and latches the offset.
REQ-019 WAIT->CAPT when posupd=0; WAIT SHALL stay while posupd=1, max 3 consecutive cycles, then SHALL go to CAPT regardless.
REQ-020 In CAPT, both 16-bit halves SHALL be sampled in the same clock into a 32-bit snapshot (no torn X/Y).
REQ-021 CAPT->DRIVE unconditionally; in DRIVE gpu_dout=snapshot, gpu_dout_en=1, gpu_rack=1 for exactly one cycle; DRIVE->IDLE next cycle.
REQ-022 Minimum latency from accepted gpu_rreq to gpu_rack SHALL be 3 cycles; maximum 6.
REQ-023 gpu_dout SHALL be 32'h0 whenever gpu_dout_en=0.
REQ-024 busy SHALL be 1 in WAIT, CAPT, DRIVE.
REQ-025 stop_sticky SHALL set on any cycle with stopped=1 and clear in the CAPT cycle of a STATUS read; if stopped=1 in that same cycle, set SHALL win and the snapshot SHALL show bit1=1.
REQ-026 Snapshot of STATUS SHALL use the stop_sticky value before that cycle's update, OR'd with stopped.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, stop_sticky=0, snapshot=0, wait counter=0, gpu_dout=0, gpu_dout_en=0, gpu_rack=0, busy=0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no gpu_rack ever issued for that request.

Structure
REQ-029 Register offsets (0x04, 0x18, 0x2C, 0x38), state encoding and WAIT limit (3) SHALL live in the shared blitter defines package.
REQ-030 The snapshot register plus offset mux SHALL be one sub-module, blitrd_cap; FSM, wait counter and sticky flag stay in blitrd_port.

Verification
REQ-031 A1POS read, a1_x=16'h0123, a1_y=16'h0456, posupd=0 -> gpu_rack 3 cycles later, gpu_dout=32'h04560123, gpu_dout_en high 1 cycle.
REQ-032 A2POS read with posupd=1 for 2 cycles, a2_x changing 5->6 on the update -> rack at cycle 5, data X=6 with matching Y.
REQ-033 posupd held 1 for 10 cycles -> forced CAPT after 3 WAIT cycles, rack at cycle 6.
REQ-034 stopped pulsed 1 cycle, then STATUS read twice with idle=1 -> first 32'h3, second 32'h1.
REQ-035 Read of offset 0x10, and gpu_rreq during busy -> first returns 32'h0; second produces no extra rack.
REQ-036 reset_n low during WAIT -> outputs zero immediately, no rack; next read completes normally in 3 cycles.

Source files
------------

// File: rtl/blitrd_port_pkg.sv
// Shared blitter read-port defines: register offsets, FSM encoding, wait limit.
package blitrd_port_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned POS_W  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OFS_W  = 6;
  localparam int unsigned WCNT_W = 2;

  localparam logic [ADDR_W-1:0] OFS_A1POS  = 8'h04;
  localparam logic [ADDR_W-1:0] OFS_A1POSF = 8'h18;
  localparam logic [ADDR_W-1:0] OFS_A2POS  = 8'h2C;
  localparam logic [ADDR_W-1:0] OFS_STATUS = 8'h38;

  // Consecutive posupd cycles tolerated in WAIT before capture is forced.
  localparam logic [WCNT_W-1:0] WAIT_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DRIVE = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } pos_pair_t;

  function automatic logic [OFS_W-1:0] word_of(input logic [ADDR_W-1:0] byte_ofs);
    return byte_ofs[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/blitrd_cap.sv
// Snapshot register and offset mux; holds data only for the cycle after capture.
module blitrd_cap
  import blitrd_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_en,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [POS_W-1:0]  a1_x,
  input  logic [POS_W-1:0]  a1_y,
  input  logic [POS_W-1:0]  a2_x,
  input  logic [POS_W-1:0]  a2_y,
  input  logic [POS_W-1:0]  a1_fx,
  input  logic [POS_W-1:0]  a1_fy,
  input  logic              idle,
  input  logic              stop_bit,
  output logic [DATA_W-1:0] snap
);

  pos_pair_t        a1_c, a1f_c, a2_c;
  logic [DATA_W-1:0] sel_c;

  assign a1_c  = '{y: a1_y,  x: a1_x};
  assign a1f_c = '{y: a1_fy, x: a1_fx};
  assign a2_c  = '{y: a2_y,  x: a2_x};

  always_comb begin
    sel_c = '0;
    case (ofs)
      word_of(OFS_A1POS):  sel_c = a1_c;
      word_of(OFS_A1POSF): sel_c = a1f_c;
      word_of(OFS_A2POS):  sel_c = a2_c;
      word_of(OFS_STATUS): sel_c = {{(DATA_W-2){1'b0}}, stop_bit, idle};
      default:             sel_c = '0;
    endcase
  end

  // Both halves load in one edge; cleared otherwise so the bus reads zero when not driven.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
    end else begin
      snap <= cap_en ? sel_c : '0;
    end
  end

endmodule

// File: rtl/blitrd_port.sv
// GPU read port onto blitter position/status registers with posupd-safe capture.
module blitrd_port
  import blitrd_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bliten,
  input  logic              gpu_memw,
  input  logic              gpu_rreq,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic              posupd,
  input  logic [POS_W-1:0]  a1_x,
  input  logic [POS_W-1:0]  a1_y,
  input  logic [POS_W-1:0]  a2_x,
  input  logic [POS_W-1:0]  a2_y,
  input  logic [POS_W-1:0]  a1_fx,
  input  logic [POS_W-1:0]  a1_fy,
  input  logic              idle,
  input  logic              stopped,
  output logic [DATA_W-1:0] gpu_dout,
  output logic              gpu_dout_en,
  output logic              gpu_rack,
  output logic              busy
);

  rd_state_t         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [OFS_W-1:0]  ofs;
  logic              stop_sticky;

  logic accept_c;
  logic capt_c;
  logic status_rd_c;
  logic stop_bit_c;
  logic addr_lsb_unused;

  assign accept_c        = gpu_rreq & bliten & ~gpu_memw & (state == ST_IDLE);
  assign capt_c          = (state == ST_CAPT);
  assign status_rd_c     = capt_c & (ofs == word_of(OFS_STATUS));
  assign stop_bit_c      = stop_sticky | stopped;
  assign addr_lsb_unused = ^gpu_addr[1:0];

  // Read FSM; rack/dout_en are set on the CAPT edge so they coincide with the snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      ofs         <= '0;
      gpu_dout_en <= 1'b0;
      gpu_rack    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gpu_dout_en <= 1'b0;
      gpu_rack    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state    <= ST_WAIT;
            ofs      <= word_of(gpu_addr);
            wait_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (posupd && (wait_cnt < WAIT_MAX)) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end else begin
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          state       <= ST_DRIVE;
          gpu_dout_en <= 1'b1;
          gpu_rack    <= 1'b1;
        end
        ST_DRIVE: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A stop seen in the same cycle as a STATUS capture re-arms the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_sticky <= 1'b0;
    end else begin
      stop_sticky <= stopped | (stop_sticky & ~status_rd_c);
    end
  end

  blitrd_cap u_cap (
    .clk      (clk),
    .reset_n  (reset_n),
    .cap_en   (capt_c),
    .ofs      (ofs),
    .a1_x     (a1_x),
    .a1_y     (a1_y),
    .a2_x     (a2_x),
    .a2_y     (a2_y),
    .a1_fx    (a1_fx),
    .a1_fy    (a1_fy),
    .idle     (idle),
    .stop_bit (stop_bit_c),
    .snap     (gpu_dout)
  );

endmodule

// File: tb/tb_blitrd_port.sv
// Scoreboard bench for blitrd_port: directed reads, monitor checks data and latency.
module tb_blitrd_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bliten, gpu_memw, gpu_rreq, posupd, idle, stopped;
  logic [7:0]  gpu_addr;
  logic [15:0] a1_x, a1_y, a2_x, a2_y, a1_fx, a1_fy;
  logic [31:0] gpu_dout;
  logic        gpu_dout_en, gpu_rack, busy;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  blitrd_port dut (
    .clk(clk), .reset_n(reset_n), .bliten(bliten), .gpu_memw(gpu_memw),
    .gpu_rreq(gpu_rreq), .gpu_addr(gpu_addr), .posupd(posupd),
    .a1_x(a1_x), .a1_y(a1_y), .a2_x(a2_x), .a2_y(a2_y),
    .a1_fx(a1_fx), .a1_fy(a1_fy), .idle(idle), .stopped(stopped),
    .gpu_dout(gpu_dout), .gpu_dout_en(gpu_dout_en), .gpu_rack(gpu_rack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: bus must be zero when undriven; each rack pops one expected read.
  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (!gpu_dout_en && gpu_dout !== 32'h0) begin
      fails++;
      $display("FAIL dout_undriven_zero: gpu_dout=%h required 00000000", gpu_dout);
    end
    tests++;
    if (gpu_rack !== gpu_dout_en) begin
      fails++;
      $display("FAIL rack_en_pair: gpu_rack=%b gpu_dout_en=%b required equal", gpu_rack, gpu_dout_en);
    end
    if (gpu_rack === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rack: rack at cycle %0d with no pending read, data=%h", cyc, gpu_dout);
      end else begin
        e = q.pop_front();
        if (gpu_dout !== e.data || (cyc - e.issue) != e.lat) begin
          fails++;
          $display("FAIL %s: data=%h latency=%0d required data=%h latency=%0d",
                   e.name, gpu_dout, cyc - e.issue, e.data, e.lat);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got=%h required=%h", nm, got, req);
    end
  endtask

  // Issue one accepted read; returns mid-way through the first WAIT cycle.
  task automatic rd(input logic [7:0] a, input logic [31:0] d, input int lat, input string nm);
    exp_t e;
    @(negedge clk);
    gpu_addr = a; gpu_memw = 1'b0; bliten = 1'b1; gpu_rreq = 1'b1;
    e.data = d; e.lat = lat; e.issue = cyc; e.name = nm;
    q.push_back(e);
    @(negedge clk);
    gpu_rreq = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL rack_timeout: %0d reads pending, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; bliten = 1'b0; gpu_memw = 1'b0; gpu_rreq = 1'b0; posupd = 1'b0;
    idle = 1'b1; stopped = 1'b0; gpu_addr = 8'h0;
    a1_x = 16'h0123; a1_y = 16'h0456; a2_x = 16'h0005; a2_y = 16'h0777;
    a1_fx = 16'hBEEF; a1_fy = 16'hCAFE;
    repeat (2) @(negedge clk);
    chk("reset_dout", gpu_dout, 32'h0);
    chk("reset_dout_en", 32'(gpu_dout_en), 32'h0);
    chk("reset_rack", 32'(gpu_rack), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // A1POS, no position update: minimum latency
    rd(8'h04, 32'h04560123, 3, "a1pos_min_latency");
    chk("busy_in_wait", 32'(busy), 32'h1);
    wait_done();
    chk("idle_after_read", 32'(busy), 32'h0);

    // A2POS while position updates for two cycles; capture sees the new X
    posupd = 1'b1;
    rd(8'h2C, 32'h07770006, 5, "a2pos_after_update");
    repeat (2) @(negedge clk);
    posupd = 1'b0; a2_x = 16'h0006;
    wait_done();

    // posupd stuck high: capture forced after the wait limit
    posupd = 1'b1;
    rd(8'h18, 32'hCAFEBEEF, 6, "a1posf_forced_capt");
    repeat (9) @(negedge clk);
    posupd = 1'b0;
    wait_done();

    // Sticky stop: set by a pulse, cleared by the STATUS capture
    @(negedge clk); stopped = 1'b1;
    @(negedge clk); stopped = 1'b0;
    rd(8'h38, 32'h3, 3, "status_sticky_set");
    wait_done();
    rd(8'h38, 32'h1, 3, "status_sticky_cleared");
    wait_done();

    // stopped high during the STATUS capture: set wins over clear
    rd(8'h38, 32'h3, 3, "status_stop_in_capt");
    stopped = 1'b1;
    repeat (2) @(negedge clk);
    stopped = 1'b0;
    wait_done();
    rd(8'h38, 32'h3, 3, "status_set_won");
    wait_done();
    idle = 1'b0;
    rd(8'h38, 32'h0, 3, "status_not_idle");
    wait_done();
    idle = 1'b1;

    // Unmapped offset, plus a request while busy that must be dropped
    rd(8'h10, 32'h0, 3, "unmapped_offset");
    gpu_addr = 8'h04; gpu_rreq = 1'b1;
    @(negedge clk); gpu_rreq = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);

    // Requests with wrong qualifiers are ignored
    bliten = 1'b0; gpu_rreq = 1'b1;
    @(negedge clk); bliten = 1'b1; gpu_memw = 1'b1;
    @(negedge clk); gpu_rreq = 1'b0; gpu_memw = 1'b0;
    @(negedge clk);
    chk("unqualified_not_busy", 32'(busy), 32'h0);
    repeat (8) @(negedge clk);

    // Reset during WAIT aborts the read with no rack
    posupd = 1'b1;
    @(negedge clk); gpu_addr = 8'h04; gpu_rreq = 1'b1;
    @(negedge clk); gpu_rreq = 1'b0;
    chk("busy_before_abort", 32'(busy), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rack", 32'(gpu_rack), 32'h0);
    chk("abort_dout_en", 32'(gpu_dout_en), 32'h0);
    chk("abort_dout", gpu_dout, 32'h0);
    @(negedge clk); reset_n = 1'b1; posupd = 1'b0;
    repeat (8) @(negedge clk);
    rd(8'h04, 32'h04560123, 3, "read_after_abort");
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
